// File: rtl/dm.sv
// Debug-module DMI request/response types shared by the DMI interconnect.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  // A single master still needs a one-bit index to address its lane.
  localparam int MinIdxWidth = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : MinIdxWidth;
  endfunction

endpackage

// File: rtl/dmi_tag_fifo.sv
// Small tag FIFO holding the issuing master index of every outstanding DMI request.
// Registered read side only: a pushed entry becomes visible on the next cycle.
module dmi_tag_fifo import dm::*; #(
  parameter  int Width    = 1,
  parameter  int Depth    = 2,
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    data_o,
  output logic [CntWidth-1:0] count_o,
  output logic                empty_o
);

  logic [Width-1:0]    mem_r [Depth];
  logic [PtrWidth-1:0] wr_ptr_r;
  logic [PtrWidth-1:0] rd_ptr_r;
  logic [CntWidth-1:0] count_r;
  logic                push_s;
  logic                pop_s;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PtrWidth-1:0] wrap_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? {PtrWidth{1'b0}} : p + PtrWidth'(1);
  endfunction

  assign push_s  = push_i && (count_r != CntWidth'(Depth));
  assign pop_s   = pop_i && (count_r != {CntWidth{1'b0}});
  assign data_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;
  assign empty_o = (count_r == {CntWidth{1'b0}});

  // Storage, pointers and fill level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_r[i] <= {Width{1'b0}};
      end
      wr_ptr_r <= {PtrWidth{1'b0}};
      rd_ptr_r <= {PtrWidth{1'b0}};
      count_r  <= {CntWidth{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= wrap_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= wrap_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntWidth'(1);
        2'b01:   count_r <= count_r - CntWidth'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// N-master to 1-slave DMI interconnect: round-robin request arbitration into a
// registered output stage, with in-order response routing via a tag FIFO.
module dmi_arbiter import dm::*; #(
  parameter  int NumMasters     = 2,
  parameter  int MaxOutstanding = 2,
  localparam int IdxWidth       = idx_width(NumMasters),
  localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  dmi_req_t  [NumMasters-1:0]       mst_req_i,
  input  logic      [NumMasters-1:0]       mst_req_valid_i,
  output logic      [NumMasters-1:0]       mst_req_ready_o,
  output dmi_resp_t [NumMasters-1:0]       mst_resp_o,
  output logic      [NumMasters-1:0]       mst_resp_valid_o,
  input  logic      [NumMasters-1:0]       mst_resp_ready_i,
  output dmi_req_t                         slv_req_o,
  output logic                             slv_req_valid_o,
  input  logic                             slv_req_ready_i,
  input  dmi_resp_t                        slv_resp_i,
  input  logic                             slv_resp_valid_i,
  output logic                             slv_resp_ready_o,
  output logic      [CntWidth-1:0]         outstanding_o,
  output logic                             err_unexp_resp_o
);

  dmi_req_t            req_r;
  logic                valid_r;
  logic [IdxWidth-1:0] ptr_r;

  int                  cand_s;
  logic [IdxWidth-1:0] cand_idx_s;
  logic                hit_s;
  logic                found_s;
  logic [IdxWidth-1:0] winner_s;
  logic [IdxWidth-1:0] next_ptr_s;
  logic                can_accept_s;
  logic                mst_hs_s;
  logic                resp_hs_s;
  logic [CntWidth-1:0] count_s;
  logic [IdxWidth-1:0] head_s;
  logic                empty_s;

  // Round-robin search starting at ptr_r, first valid master in modular order
  always_comb begin
    found_s    = 1'b0;
    winner_s   = ptr_r;
    cand_s     = 0;
    cand_idx_s = ptr_r;
    hit_s      = 1'b0;
    for (int k = 0; k < NumMasters; k++) begin
      cand_s     = (int'(ptr_r) + k >= NumMasters) ? int'(ptr_r) + k - NumMasters
                                                   : int'(ptr_r) + k;
      cand_idx_s = IdxWidth'(cand_s);
      hit_s      = !found_s && mst_req_valid_i[cand_idx_s];
      winner_s   = hit_s ? cand_idx_s : winner_s;
      found_s    = found_s | hit_s;
    end
  end

  // Full FIFO blocks acceptance even if a response pops this cycle.
  assign can_accept_s = !rst_i && (!valid_r || slv_req_ready_i) &&
                        (count_s < CntWidth'(MaxOutstanding));
  assign mst_hs_s     = can_accept_s && found_s;
  assign next_ptr_s   = (winner_s == IdxWidth'(NumMasters - 1)) ? {IdxWidth{1'b0}}
                                                                 : winner_s + IdxWidth'(1);

  // Single-grant ready vector
  always_comb begin
    mst_req_ready_o           = {NumMasters{1'b0}};
    mst_req_ready_o[winner_s] = mst_hs_s;
  end

  // Registered output stage and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_r   <= {$bits(dmi_req_t){1'b0}};
      valid_r <= 1'b0;
      ptr_r   <= {IdxWidth{1'b0}};
    end else if (mst_hs_s) begin
      req_r   <= mst_req_i[winner_s];
      valid_r <= 1'b1;
      ptr_r   <= next_ptr_s;
    end else if (slv_req_ready_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign slv_req_o       = req_r;
  assign slv_req_valid_o = valid_r;

  dmi_tag_fifo #(
    .Width (IdxWidth),
    .Depth (MaxOutstanding)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (mst_hs_s),
    .data_i  (winner_s),
    .pop_i   (resp_hs_s),
    .data_o  (head_s),
    .count_o (count_s),
    .empty_o (empty_s)
  );

  // Route the slave response to the oldest outstanding master; drop it when none is waiting
  always_comb begin
    mst_resp_valid_o = {NumMasters{1'b0}};
    slv_resp_ready_o = 1'b0;
    if (rst_i) begin
      slv_resp_ready_o = 1'b0;
    end else if (empty_s) begin
      slv_resp_ready_o = 1'b1;
    end else begin
      mst_resp_valid_o[head_s] = slv_resp_valid_i;
      slv_resp_ready_o         = mst_resp_ready_i[head_s];
    end
  end

  assign resp_hs_s        = slv_resp_valid_i && slv_resp_ready_o && !empty_s;
  assign err_unexp_resp_o = !rst_i && slv_resp_valid_i && empty_s;
  assign mst_resp_o       = {NumMasters{slv_resp_i}};
  assign outstanding_o    = count_s;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter (3 masters, 2 outstanding) with request/response scoreboards.
module tb_dmi_arbiter;
  import dm::*;

  localparam int NM = 3;
  localparam int MO = 2;
  localparam int CW = $clog2(MO + 1);

  logic                clk = 1'b0;
  logic                rst_i;
  dmi_req_t  [NM-1:0]  mst_req_i;
  logic      [NM-1:0]  mst_req_valid_i;
  logic      [NM-1:0]  mst_req_ready_o;
  dmi_resp_t [NM-1:0]  mst_resp_o;
  logic      [NM-1:0]  mst_resp_valid_o;
  logic      [NM-1:0]  mst_resp_ready_i;
  dmi_req_t            slv_req_o;
  logic                slv_req_valid_o;
  logic                slv_req_ready_i;
  dmi_resp_t           slv_resp_i;
  logic                slv_resp_valid_i;
  logic                slv_resp_ready_o;
  logic      [CW-1:0]  outstanding_o;
  logic                err_unexp_resp_o;

  int total = 0;
  int bad   = 0;
  dmi_req_t   exp_req_q[$];
  logic [1:0] exp_mst_q[$];

  dmi_arbiter #(.NumMasters(NM), .MaxOutstanding(MO)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .mst_req_i        (mst_req_i),
    .mst_req_valid_i  (mst_req_valid_i),
    .mst_req_ready_o  (mst_req_ready_o),
    .mst_resp_o       (mst_resp_o),
    .mst_resp_valid_o (mst_resp_valid_o),
    .mst_resp_ready_i (mst_resp_ready_i),
    .slv_req_o        (slv_req_o),
    .slv_req_valid_o  (slv_req_valid_o),
    .slv_req_ready_i  (slv_req_ready_i),
    .slv_resp_i       (slv_resp_i),
    .slv_resp_valid_i (slv_resp_valid_i),
    .slv_resp_ready_o (slv_resp_ready_o),
    .outstanding_o    (outstanding_o),
    .err_unexp_resp_o (err_unexp_resp_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic dmi_req_t mk_req(input logic [6:0] a, input dtm_op_e o, input logic [31:0] d);
    dmi_req_t r;
    r.addr = a;
    r.op   = o;
    r.data = d;
    return r;
  endfunction

  task automatic expect_accept(input dmi_req_t r, input logic [1:0] m);
    exp_req_q.push_back(r);
    exp_mst_q.push_back(m);
  endtask

  // Scoreboard: slave-side request order and response routing
  task automatic mon();
    dmi_req_t   er;
    logic [1:0] m;
    logic [NM-1:0] oh;
    if (!rst_i) begin
      if (slv_req_valid_o && slv_req_ready_i) begin
        chk("sb_req_pending", 64'(exp_req_q.size() != 0), 64'(1'b1));
        if (exp_req_q.size() != 0) begin
          er = exp_req_q.pop_front();
          chk("sb_req", 64'(slv_req_o), 64'(er));
        end
      end
      if (slv_resp_valid_i) begin
        if (exp_mst_q.size() == 0) begin
          chk("unexp_err", 64'(err_unexp_resp_o), 64'(1'b1));
          chk("unexp_valid", 64'(mst_resp_valid_o), 64'(3'b000));
          chk("unexp_ready", 64'(slv_resp_ready_o), 64'(1'b1));
        end else begin
          m     = exp_mst_q[0];
          oh    = 3'b000;
          oh[m] = 1'b1;
          chk("sb_resp_route", 64'(mst_resp_valid_o), 64'(oh));
          chk("sb_resp_data", 64'(mst_resp_o[m]), 64'(slv_resp_i));
          chk("sb_resp_ready", 64'(slv_resp_ready_o), 64'(mst_resp_ready_i[m]));
          chk("sb_no_err", 64'(err_unexp_resp_o), 64'(1'b0));
          if (mst_resp_ready_i[m]) begin
            void'(exp_mst_q.pop_front());
          end
        end
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    mon();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i            = 1'b1;
    mst_req_valid_i  = 3'b000;
    slv_resp_valid_i = 1'b0;
    slv_req_ready_i  = 1'b1;
    mst_resp_ready_i = 3'b111;
    exp_req_q.delete();
    exp_mst_q.delete();
    nxt();
    rst_i = 1'b0;
  endtask

  logic [NM-1:0] fair_rdy [8] = '{3'b001, 3'b010, 3'b000, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
  dmi_req_t bp_req;

  initial begin
    // Reset values with every input trying to provoke activity
    rst_i            = 1'b1;
    mst_req_i        = '0;
    mst_req_valid_i  = 3'b111;
    mst_resp_ready_i = 3'b111;
    slv_req_ready_i  = 1'b1;
    slv_resp_i       = '0;
    slv_resp_valid_i = 1'b1;
    neg();
    chk("rst_req_ready", 64'(mst_req_ready_o), 64'(3'b000));
    chk("rst_slv_valid", 64'(slv_req_valid_o), 64'(1'b0));
    chk("rst_slv_req", 64'(slv_req_o), 64'(41'h0));
    chk("rst_outstanding", 64'(outstanding_o), 64'(2'd0));
    chk("rst_err", 64'(err_unexp_resp_o), 64'(1'b0));
    chk("rst_resp_valid", 64'(mst_resp_valid_o), 64'(3'b000));
    chk("rst_resp_ready", 64'(slv_resp_ready_o), 64'(1'b0));
    nxt();

    // Fairness: all masters valid, slave always ready and responding from cycle 2
    do_reset();
    for (int i = 0; i < NM; i++) begin
      mst_req_i[2'(i)] = mk_req(7'(8'h20 + i), (i == 2) ? DTM_NOP : DTM_READ, 32'(i * 16));
    end
    for (int c = 0; c < 8; c++) begin
      mst_req_valid_i  = (c < 7) ? 3'b111 : 3'b000;
      slv_resp_valid_i = (c >= 2);
      slv_resp_i.data  = 32'hA000_0000 + 32'(c);
      slv_resp_i.resp  = 2'b00;
      neg();
      chk($sformatf("fair_rdy_c%0d", c), 64'(mst_req_ready_o), 64'(fair_rdy[c]));
      for (int i = 0; i < NM; i++) begin
        if (fair_rdy[c][2'(i)]) expect_accept(mst_req_i[2'(i)], 2'(i));
      end
      nxt();
      for (int i = 0; i < NM; i++) begin
        if (fair_rdy[c][2'(i)]) mst_req_i[2'(i)].data = mst_req_i[2'(i)].data + 32'd1;
      end
    end
    slv_resp_valid_i = 1'b0;
    neg();
    chk("fair_drained", 64'(outstanding_o), 64'(2'd0));
    chk("fair_resp_q", 64'(exp_mst_q.size()), 64'(0));
    nxt();

    // Latency / throughput / full with simultaneous pop, single master
    do_reset();
    mst_req_valid_i = 3'b001;
    mst_req_i[0]    = mk_req(7'h04, DTM_READ, 32'h0);
    neg();
    chk("lat_rdy0", 64'(mst_req_ready_o), 64'(3'b001));
    chk("lat_valid0", 64'(slv_req_valid_o), 64'(1'b0));
    chk("lat_out0", 64'(outstanding_o), 64'(2'd0));
    expect_accept(mst_req_i[0], 2'd0);
    nxt();
    mst_req_i[0].addr = 7'h05;
    neg();
    chk("lat_valid1", 64'(slv_req_valid_o), 64'(1'b1));
    chk("lat_rdy1", 64'(mst_req_ready_o), 64'(3'b001));
    chk("lat_out1", 64'(outstanding_o), 64'(2'd1));
    expect_accept(mst_req_i[0], 2'd0);
    nxt();
    mst_req_i[0].addr = 7'h06;
    neg();
    chk("lat_full_rdy", 64'(mst_req_ready_o), 64'(3'b000));
    chk("lat_out2", 64'(outstanding_o), 64'(2'd2));
    chk("lat_valid2", 64'(slv_req_valid_o), 64'(1'b1));
    nxt();
    neg();
    chk("lat_valid3", 64'(slv_req_valid_o), 64'(1'b0));
    chk("lat_stall_rdy", 64'(mst_req_ready_o), 64'(3'b000));
    nxt();
    slv_resp_valid_i = 1'b1;
    slv_resp_i       = '{data: 32'h1111_0004, resp: 2'b00};
    neg();
    chk("popfull_rdy", 64'(mst_req_ready_o), 64'(3'b000));
    chk("popfull_out", 64'(outstanding_o), 64'(2'd2));
    nxt();
    slv_resp_valid_i = 1'b0;
    neg();
    chk("popfull_out_after", 64'(outstanding_o), 64'(2'd1));
    chk("popfull_rdy_after", 64'(mst_req_ready_o), 64'(3'b001));
    expect_accept(mst_req_i[0], 2'd0);
    nxt();
    mst_req_valid_i = 3'b000;
    neg();
    chk("popfull_out_refill", 64'(outstanding_o), 64'(2'd2));
    chk("popfull_valid", 64'(slv_req_valid_o), 64'(1'b1));
    nxt();
    slv_resp_valid_i = 1'b1;
    slv_resp_i       = '{data: 32'h1111_0005, resp: 2'b00};
    neg(); nxt();
    slv_resp_i       = '{data: 32'h1111_0006, resp: 2'b10};
    neg(); nxt();
    slv_resp_valid_i = 1'b0;
    neg();
    chk("lat_drained", 64'(outstanding_o), 64'(2'd0));
    nxt();

    // Backpressure: slave not ready, output stage must hold its request
    do_reset();
    slv_req_ready_i = 1'b0;
    bp_req          = mk_req(7'h10, DTM_WRITE, 32'hDEAD_BEEF);
    mst_req_i[1]    = bp_req;
    mst_req_valid_i = 3'b010;
    neg();
    chk("bp_rdy0", 64'(mst_req_ready_o), 64'(3'b010));
    expect_accept(mst_req_i[1], 2'd1);
    nxt();
    mst_req_i[1]    = mk_req(7'h11, DTM_NOP, 32'h0);
    mst_req_i[2]    = mk_req(7'h12, DTM_READ, 32'h2);
    mst_req_valid_i = 3'b110;
    for (int c = 0; c < 5; c++) begin
      neg();
      chk($sformatf("bp_hold_c%0d", c), 64'(slv_req_o), 64'(bp_req));
      chk($sformatf("bp_valid_c%0d", c), 64'(slv_req_valid_o), 64'(1'b1));
      chk($sformatf("bp_rdy_c%0d", c), 64'(mst_req_ready_o), 64'(3'b000));
      nxt();
    end
    slv_req_ready_i = 1'b1;
    neg();
    chk("bp_release_rdy", 64'(mst_req_ready_o), 64'(3'b100));
    expect_accept(mst_req_i[2], 2'd2);
    nxt();
    mst_req_valid_i = 3'b010;
    neg();
    chk("bp_full_out", 64'(outstanding_o), 64'(2'd2));
    chk("bp_full_rdy", 64'(mst_req_ready_o), 64'(3'b000));
    nxt();
    mst_req_valid_i = 3'b000;

    // Response stall: master 1 refuses its response for 4 cycles
    mst_resp_ready_i = 3'b101;
    slv_resp_valid_i = 1'b1;
    slv_resp_i       = '{data: 32'h5555_AAAA, resp: 2'b00};
    for (int c = 0; c < 4; c++) begin
      neg();
      chk($sformatf("rs_ready_c%0d", c), 64'(slv_resp_ready_o), 64'(1'b0));
      chk($sformatf("rs_out_c%0d", c), 64'(outstanding_o), 64'(2'd2));
      nxt();
    end
    mst_resp_ready_i = 3'b111;
    neg();
    chk("rs_release_ready", 64'(slv_resp_ready_o), 64'(1'b1));
    nxt();
    neg();
    chk("rs_out_after_pop", 64'(outstanding_o), 64'(2'd1));
    nxt();
    slv_resp_valid_i = 1'b0;
    neg();
    chk("rs_drained", 64'(outstanding_o), 64'(2'd0));
    nxt();

    // Reset mid-transaction, then a stale response is flagged as unexpected
    do_reset();
    mst_req_i[0]    = mk_req(7'h30, DTM_READ, 32'h0);
    mst_req_i[2]    = mk_req(7'h32, DTM_WRITE, 32'h32);
    mst_req_valid_i = 3'b101;
    neg();
    chk("mr_rdy0", 64'(mst_req_ready_o), 64'(3'b001));
    expect_accept(mst_req_i[0], 2'd0);
    nxt();
    neg();
    chk("mr_rdy1", 64'(mst_req_ready_o), 64'(3'b100));
    expect_accept(mst_req_i[2], 2'd2);
    nxt();
    rst_i            = 1'b1;
    slv_resp_valid_i = 1'b1;
    #1;
    chk("mr_rst_slv_valid", 64'(slv_req_valid_o), 64'(1'b0));
    chk("mr_rst_out", 64'(outstanding_o), 64'(2'd0));
    chk("mr_rst_rdy", 64'(mst_req_ready_o), 64'(3'b000));
    chk("mr_rst_resp_valid", 64'(mst_resp_valid_o), 64'(3'b000));
    chk("mr_rst_err", 64'(err_unexp_resp_o), 64'(1'b0));
    exp_req_q.delete();
    exp_mst_q.delete();
    nxt();
    rst_i           = 1'b0;
    mst_req_valid_i = 3'b000;
    slv_resp_i      = '{data: 32'hBAD0_0000, resp: 2'b00};
    neg();
    chk("mr_stale_err", 64'(err_unexp_resp_o), 64'(1'b1));
    nxt();
    slv_resp_valid_i = 1'b0;
    neg();
    chk("mr_err_pulse_end", 64'(err_unexp_resp_o), 64'(1'b0));
    chk("mr_out_final", 64'(outstanding_o), 64'(2'd0));
    nxt();

    chk("end_req_q", 64'(exp_req_q.size()), 64'(0));
    chk("end_resp_q", 64'(exp_mst_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
Single-clock N-master to 1-slave DMI interconnect. It merges several DMI request sources, such as the JTAG DTM path after its CDC and a system-bus debug port, onto one debug-module DMI port. Requests pass through a registered output stage under round-robin arbitration. Responses are routed back in order to the issuing master through an internal tag FIFO that tracks outstanding transactions.

Parameters:
NumMasters, 2, number of DMI request sources (≥1)
MaxOutstanding, 2, depth of the tag FIFO, i.e. the maximum number of issued requests without a response (≥1)
IdxWidth, derived, $clog2(NumMasters) with a minimum of 1; not user-overridable

Ports:
clk_i  in  1  sole clock
rst_i  in  1  asynchronous active-high reset
mst_req_i  in  NumMasters x dm::dmi_req_t  per-master request (addr, op, data)
mst_req_valid_i  in  NumMasters  request valid
mst_req_ready_o  out  NumMasters  request accepted
mst_resp_o  out  NumMasters x dm::dmi_resp_t  per-master response (all lanes carry the slave response)
mst_resp_valid_o  out  NumMasters  response valid, one-hot or zero
mst_resp_ready_i  in  NumMasters  master accepts response
slv_req_o  out  dm::dmi_req_t  request to the debug module
slv_req_valid_o  out  1  registered request valid
slv_req_ready_i  in  1  debug module accepts request
slv_resp_i  in  dm::dmi_resp_t  debug module response
slv_resp_valid_i  in  1  response valid
slv_resp_ready_o  out  1  response accepted
outstanding_o  out  $clog2(MaxOutstanding+1)  current tag FIFO fill level
err_unexp_resp_o  out  1  one-cycle pulse when a response arrives with no outstanding tag

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted:
  - All valid and ready outputs are 0, slv_req_o is all zero, outstanding_o is 0 and err_unexp_resp_o is 0.
  - The round-robin pointer is 0 and the tag FIFO is empty.
  - In-flight transactions are discarded; no response is replayed after reset.
- Output stage: one register (req_q, valid_q, idx_q).
  - can_accept = (!valid_q || slv_req_ready_i) && (count < MaxOutstanding).
  - count is the tag FIFO fill level, sampled before this cycle's push or pop; no bypass is allowed when full.
- Arbitration is combinational round-robin.
  - The search starts at pointer ptr and takes the first i with mst_req_valid_i[i], in modular order.
  - mst_req_ready_o[i] = can_accept && (i == winner). At most one master is ready in any cycle.
  - On a master handshake: req_q is loaded with the winner's request, valid_q=1, and ptr = (winner+1) mod NumMasters.
  - When there is no handshake, ptr holds its value.
- Latency: a request accepted in cycle t appears on slv_req_o with slv_req_valid_o=1 in cycle t+1.
- Back-to-back requests sustain 1 per cycle while slv_req_ready_i=1 and the FIFO is not full.
- A slave handshake with no new request accepted in the same cycle clears valid_q.
- slv_req_o stays stable while slv_req_valid_o=1 and slv_req_ready_i=0.
- Tag FIFO:
  - The winner index is pushed on the master request handshake. The tag is allocated at acceptance, not at slave handshake.
  - The head entry is popped on the slave response handshake.
- Response routing is combinational, with no added latency:
  - When the FIFO is non-empty: mst_resp_valid_o[head] = slv_resp_valid_i and slv_resp_ready_o = mst_resp_ready_i[head].
  - The other valid bits are 0.
- Unexpected response: slv_resp_valid_i=1 with the FIFO empty.
  - slv_resp_ready_o=1, so the response is dropped.
  - err_unexp_resp_o pulses for that cycle and no master sees a valid.
- Simultaneous push and pop keep count unchanged. Pop and push in the same cycle are legal when count==MaxOutstanding only for the pop, because can_accept uses the pre-pop count.
- FIFO pointers wrap modulo MaxOutstanding. Non-power-of-two depths must work.
- NumMasters=1 degenerates to a registered pass-through with tracking. ptr stays 0.
- dmi op NOP requests are forwarded and tracked like any other operation. The debug module responds to every request.

Decomposition:
- Package dm (existing): dmi_req_t and dmi_resp_t. The localparam giving the minimum index width is added there.
- Sub-module dmi_tag_fifo: a parametrised width/depth FIFO with count output, async active-high reset and no fall-through. It holds the master indices.
- Round-robin arbitration logic stays inline.

Test Plan:
- Reset mid-transaction: 2 requests accepted, assert rst_i -> all valids 0 and outstanding_o=0 immediately. After release, a stale slv_resp_valid_i produces err_unexp_resp_o=1 for 1 cycle.
- Fairness: NumMasters=3, all masters continuously valid, slave always ready and responding -> grant order 0,1,2,0,1,2, and each response reaches the issuing master in order.
- Latency/throughput: single master issuing 8 reads to addrs 0x04..0x0B with slave ready -> slv_req_valid_o first high 1 cycle after the first accept, then 1 request per cycle until count hits MaxOutstanding=2, after which the master is stalled.
- Backpressure: slv_req_ready_i=0 for 5 cycles with req_q={addr 0x10, op write, data 0xDEADBEEF} -> slv_req_o stable and unchanged, and all mst_req_ready_o=0 once the FIFO is full.
- Response stall: master 1 holds mst_resp_ready_i=0 for 4 cycles -> slv_resp_ready_o=0, the FIFO head is not popped and outstanding_o is unchanged. Releasing ready pops the head in that cycle.
- Full with simultaneous pop: MaxOutstanding=2 and full, response handshake in the same cycle as a pending request -> request not accepted this cycle and outstanding_o goes 2→1. The request is accepted next cycle and outstanding_o returns to 2.
